reg_file_ctrl: RTL and testbench

- Command-driven master for the 2-read/1-write register file (reg_file).
- Accepts WRITE, READ, COPY and CLEAR commands over a valid/ready handshake and drives the register-file write and read ports.
- Returns read results over a valid/ready response channel.
- Sits between a host or test sequencer and reg_file, replacing ad-hoc direct port driving.

---
 rtl/rf_ctrl_pkg.sv | 18 +
 rtl/reg_file_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_file_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the register-file command controller.
package rf_ctrl_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RSP  = 3'd3,
    ST_CP   = 3'd4,
    ST_CLR  = 3'd5
  } state_e;

endpackage

// File: rtl/reg_file_ctrl.sv
// Command-driven master for a 2-read/1-write register file (WRITE/READ/COPY/CLEAR).
// Optional RF_CTRL_PERF_CNT_EN adds accepted-command and busy-cycle counters.
module reg_file_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic [DATA_WIDTH-1:0] rsp_data2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
`ifdef RF_CTRL_PERF_CNT_EN
  output logic [31:0]           perf_cmd_cnt,
  output logic [31:0]           perf_busy_cnt,
`endif
  input  logic [DATA_WIDTH-1:0] rf_rdata2
);

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp1_q, rsp1_d, rsp2_q, rsp2_d;
  logic                  accept;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data1 = rsp1_q;
  assign rsp_data2 = rsp2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ONE;
      rsp_valid_q <= 1'b0;
      rsp1_q      <= '0;
      rsp2_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp1_q      <= rsp1_d;
      rsp2_q      <= rsp2_d;
      // Fields are latched at accept so the host may drop them right away
      if (accept) begin
        a_q    <= cmd_addr_a;
        b_q    <= cmd_addr_b;
        data_q <= cmd_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp1_d      = rsp1_q;
    rsp2_d      = rsp2_q;
    rf_wen      = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_raddr1   = '0;
    rf_raddr2   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_WRITE: state_d = ST_WR;
            OP_READ:  state_d = ST_RD;
            OP_COPY:  state_d = ST_CP;
            default:  state_d = ST_CLR;
          endcase
        end
      end
      ST_WR: begin
        rf_waddr = a_q;
        rf_wdata = data_q;
        rf_wen   = (a_q != '0);
        state_d  = ST_IDLE;
      end
      ST_RD: begin
        rf_raddr1   = a_q;
        rf_raddr2   = b_q;
        rsp1_d      = rf_rdata1;
        rsp2_d      = rf_rdata2;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_CP: begin
        // Read data passes straight through to the write port in one cycle
        rf_raddr1 = a_q;
        rf_waddr  = b_q;
        rf_wdata  = rf_rdata1;
        rf_wen    = (b_q != '0);
        state_d   = ST_IDLE;
      end
      ST_CLR: begin
        rf_wen   = 1'b1;
        rf_waddr = cnt_q;
        if (cnt_q == CNT_MAX) begin
          cnt_d   = CNT_ONE;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RF_CTRL_PERF_CNT_EN
  logic [31:0] cmd_cnt_q, busy_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_cnt_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (accept) cmd_cnt_q <= cmd_cnt_q + 32'd1;
      if (state_q != ST_IDLE && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign perf_cmd_cnt  = cmd_cnt_q;
  assign perf_busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Randomized + directed bench for reg_file_ctrl with a command-level reference model.
module tb_reg_file_ctrl;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr_a, cmd_addr_b;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data1, rsp_data2;
  logic        rf_wen;
  logic [4:0]  rf_waddr, rf_raddr1, rf_raddr2;
  logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
`ifdef RF_CTRL_PERF_CNT_EN
  logic [31:0] perf_cmd_cnt, perf_busy_cnt;
`endif

  reg_file_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
`ifdef RF_CTRL_PERF_CNT_EN
    .perf_cmd_cnt(perf_cmd_cnt), .perf_busy_cnt(perf_busy_cnt),
`endif
    .rf_rdata2(rf_rdata2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file the controller drives (not reset by rst)
  logic [31:0] tb_rf [32];
  logic        rf_clr;
  always_ff @(posedge clk) begin
    if (rf_clr) for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
    else if (rf_wen && rf_waddr != 5'd0) tb_rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : tb_rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : tb_rf[rf_raddr2];

  int vectors = 0, miscompares = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: each accepted command expands into a list of expected busy cycles
  typedef struct {
    bit        wen;
    bit [4:0]  waddr, ra1, ra2;
    bit [31:0] wdata;
    bit        rd;
    bit [31:0] r1, r2;
  } cyc_t;

  cyc_t      exp_q[$];
  bit        rsp_pend;
  bit [31:0] m_rsp1, m_rsp2;
  bit [31:0] m_rf [32];

  function automatic cyc_t mk(bit wen, bit [4:0] wa, bit [31:0] wd, bit [4:0] a1, bit [4:0] a2,
                              bit rd, bit [31:0] r1, bit [31:0] r2);
    cyc_t c;
    c.wen = wen; c.waddr = wa; c.wdata = wd; c.ra1 = a1; c.ra2 = a2;
    c.rd = rd; c.r1 = r1; c.r2 = r2;
    return c;
  endfunction

  initial begin
    cyc_t c;
    rsp_pend = 0; m_rsp1 = 0; m_rsp2 = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        rsp_pend = 0; m_rsp1 = 0; m_rsp2 = 0;
      end else if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        if (c.wen) m_rf[c.waddr] = c.wdata;
        if (c.rd) begin rsp_pend = 1; m_rsp1 = c.r1; m_rsp2 = c.r2; end
      end else if (rsp_pend) begin
        if (rsp_ready) rsp_pend = 0;
      end else if (cmd_valid) begin
        case (cmd_op)
          2'b00: exp_q.push_back(mk(cmd_addr_a != 0, cmd_addr_a, cmd_data, 0, 0, 0, 0, 0));
          2'b01: exp_q.push_back(mk(0, 0, 0, cmd_addr_a, cmd_addr_b, 1,
                                    m_rf[cmd_addr_a], m_rf[cmd_addr_b]));
          2'b10: exp_q.push_back(mk(cmd_addr_b != 0, cmd_addr_b, m_rf[cmd_addr_a],
                                    cmd_addr_a, 0, 0, 0, 0));
          default: for (int i = 1; i < 32; i++) exp_q.push_back(mk(1, 5'(i), 0, 0, 0, 0, 0, 0));
        endcase
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin
    bit er, ew, ev;
    bit [4:0]  ewa, e1, e2;
    bit [31:0] ewd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        er = 0; ew = 0; ev = 0; ewa = 0; e1 = 0; e2 = 0; ewd = 0;
        if (exp_q.size() != 0) begin
          ew = exp_q[0].wen; ewa = exp_q[0].waddr; ewd = exp_q[0].wdata;
          e1 = exp_q[0].ra1; e2 = exp_q[0].ra2;
        end else if (rsp_pend) ev = 1;
        else er = 1;
        chk("cmd_ready", cmd_ready, er);
        chk("rf_wen", rf_wen, ew);
        chk("rf_waddr", rf_waddr, ewa);
        chk("rf_wdata", rf_wdata, ewd);
        chk("rf_raddr1", rf_raddr1, e1);
        chk("rf_raddr2", rf_raddr2, e2);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_data1", rsp_data1, m_rsp1);
        chk("rsp_data2", rsp_data2, m_rsp2);
      end
    end
  end

  // Response consumer: 0 = always ready, 1 = random, 2 = stalled
  int rr_mode = 0;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin chk("send_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr_a = 5'($urandom); cmd_addr_b = 5'($urandom);
    cmd_data = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready && !rsp_valid) break;
      n++;
      if (n > 500) begin chk("idle_timeout", 0, 1); break; end
    end
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) send(2'b00, 5'(i), 0, 32'(i));
  endtask

  initial begin
    int cnt, bad;
    rst = 1'b1; rf_clr = 1'b1; cmd_valid = 1'b0;
    cmd_op = 0; cmd_addr_a = 0; cmd_addr_b = 0; cmd_data = 0;
    repeat (3) @(negedge clk);
    rf_clr = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data1", rsp_data1, 0);

    // WRITE then READ, response one cycle after accept
    send(2'b00, 3, 0, 32'h0030_0000);
    send(2'b01, 3, 0, 0);
    @(negedge clk); chk("rd_lat_valid0", rsp_valid, 0);
    @(negedge clk); chk("rd_lat_valid1", rsp_valid, 1);
    chk("rd3_data1", rsp_data1, 32'h0030_0000);
    chk("rd3_data2", rsp_data2, 0);
    wait_idle();

    // Writes to register 0 are suppressed
    send(2'b00, 0, 0, 32'hFFFF_FFFF);
    @(negedge clk); chk("wr0_wen", rf_wen, 0);
    send(2'b01, 0, 0, 0);
    wait_idle(); chk("rd0_data1", rsp_data1, 0);

    // COPY 22 -> 6
    send(2'b00, 22, 0, 32'h000D_0000);
    send(2'b10, 22, 6, 0);
    @(negedge clk);
    chk("cp_wen", rf_wen, 1); chk("cp_waddr", rf_waddr, 6); chk("cp_wdata", rf_wdata, 32'h000D_0000);
    @(negedge clk); chk("cp_wen_drop", rf_wen, 0);
    send(2'b01, 6, 22, 0);
    wait_idle();
    chk("cp_rd1", rsp_data1, 32'h000D_0000); chk("cp_rd2", rsp_data2, 32'h000D_0000);

    // Full CLEAR: ready low exactly 31 cycles
    fill_index();
    send(2'b11, 0, 0, 0);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready || cnt > 100) break;
      cnt++;
    end
    chk("clr_busy_cycles", cnt, 31);
    bad = 0;
    for (int i = 0; i < 32; i++) if (tb_rf[i] !== 32'd0) bad++;
    chk("clr_all_zero", bad, 0);
    repeat (4) begin
      send(2'b01, 5'($urandom), 5'($urandom), 0);
      wait_idle();
    end

    // Stalled response holds data and blocks commands
    send(2'b00, 5, 0, 32'h0000_A5A5);
    send(2'b00, 7, 0, 32'h0000_5A5A);
    wait_idle();
    rr_mode = 2;
    @(posedge clk); #2;
    send(2'b01, 5, 7, 0);
    repeat (6) @(negedge clk);
    chk("stall_ready", cmd_ready, 0); chk("stall_valid", rsp_valid, 1);
    chk("stall_d1", rsp_data1, 32'h0000_A5A5); chk("stall_d2", rsp_data2, 32'h0000_5A5A);
    rr_mode = 0;
    @(posedge clk); #2;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_ready", cmd_ready, 1); chk("stall_release_valid", rsp_valid, 0);

    // Reset in the middle of CLEAR at counter 10
    fill_index();
    send(2'b11, 0, 0, 0);
    cnt = 0;
    forever begin
      @(negedge clk);
      if ((rf_wen && rf_waddr == 5'd10) || cnt > 100) break;
      cnt++;
    end
    rst = 1'b1;
    #1 chk("midclr_rst_wen", rf_wen, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i < 32; i++)
      if (tb_rf[i] !== ((i < 10) ? 32'd0 : 32'(i))) bad++;
    chk("midclr_partial", bad, 0);
    send(2'b00, 9, 0, 32'h99);
    send(2'b01, 9, 10, 0);
    wait_idle();
    chk("post_rst_d1", rsp_data1, 32'h99); chk("post_rst_d2", rsp_data2, 10);

    // Randomized traffic with a random consumer
    rr_mode = 1;
    for (int k = 0; k < 300; k++) begin
      int sel = $urandom_range(0, 19);
      logic [1:0] op = (sel == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      send(op, 5'($urandom), 5'($urandom), $urandom);
    end
    rr_mode = 0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
    $fatal(1);
  end

endmodule
